// File: rtl/aes_pkg.sv
// AES byte-substitution tables shared by the round datapath and key expansion.
package aes_pkg;

  typedef logic [7:0] aes_byte_t;

  localparam aes_byte_t SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam aes_byte_t SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic aes_byte_t sbox_fwd(input aes_byte_t b);
    return SBOX_FWD[b];
  endfunction

  function automatic aes_byte_t sbox_inv(input aes_byte_t b);
    return SBOX_INV[b];
  endfunction

endpackage

// File: rtl/aes_sbox_dual.sv
// One combinational byte lane: forward or inverse AES S-box selected by inv.
module aes_sbox_dual
  import aes_pkg::*;
(
  input  logic [7:0] data,
  input  logic       inv,
  output logic [7:0] sub
);

  always_comb begin
    sub = inv ? sbox_inv(data) : sbox_fwd(data);
  end

endmodule

// File: rtl/aes_subbytes_pipe.sv
// LANES-wide AES SubBytes/InvSubBytes with a PIPE-deep valid/ready register chain.
module aes_subbytes_pipe
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 16,
  parameter int unsigned PIPE  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [8*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_inv,
  output logic [8*LANES-1:0] out_data,
  output logic               busy
);

  localparam int unsigned W = 8 * LANES;

  logic [W-1:0]    sub_data;
  logic [PIPE-1:0] st_v;
  logic [PIPE-1:0] st_inv;
  logic [W-1:0]    st_data [PIPE];
  logic [PIPE-1:0] room;
  logic [PIPE-1:0] src_v;
  logic [PIPE-1:0] src_inv;
  logic [W-1:0]    src_data [PIPE];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    aes_sbox_dual u_sbox (
      .data (in_data[8*i +: 8]),
      .inv  (in_inv),
      .sub  (sub_data[8*i +: 8])
    );
  end

  // room[k]: stage k loads this cycle. Evaluated tail-to-head; !v || (v && r)
  // collapses to !v || r, so the chain carries a single bit.
  always_comb begin
    logic chain;
    room  = '0;
    chain = out_ready;
    for (int unsigned j = 0; j < PIPE; j++) begin
      chain             = !st_v[PIPE-1-j] || chain;
      room[PIPE-1-j]    = chain;
    end
  end

  always_comb begin
    src_v       = '0;
    src_inv     = '0;
    src_v[0]    = in_valid;
    src_inv[0]  = in_inv;
    src_data[0] = sub_data;
    for (int unsigned k = 1; k < PIPE; k++) begin
      src_v[k]    = st_v[k-1];
      src_inv[k]  = st_inv[k-1];
      src_data[k] = st_data[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_v   <= '0;
      st_inv <= '0;
      for (int unsigned k = 0; k < PIPE; k++) begin
        st_data[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < PIPE; k++) begin
        if (room[k]) begin
          st_v[k]    <= src_v[k];
          st_inv[k]  <= src_inv[k];
          st_data[k] <= src_data[k];
        end
      end
    end
  end

  always_comb begin
    in_ready  = room[0];
    out_valid = st_v[PIPE-1];
    out_inv   = st_inv[PIPE-1];
    out_data  = st_data[PIPE-1];
    busy      = |st_v;
  end

endmodule

// File: tb/tb_aes_subbytes_pipe.sv
// Bench for aes_subbytes_pipe: S-box reference built from GF(2^8) inversion plus affine map.
module tb_aes_subbytes_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic         a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready, a_out_inv, a_busy;
  logic [31:0]  a_in_data, a_out_data;
  logic         b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_out_inv, b_busy;
  logic [127:0] b_in_data, b_out_data;

  aes_subbytes_pipe #(.LANES(4), .PIPE(3)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_inv(a_out_inv), .out_data(a_out_data),
    .busy(a_busy)
  );

  aes_subbytes_pipe #(.LANES(16), .PIPE(1)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_inv(b_out_inv), .out_data(b_out_data),
    .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_fwd [256];
  logic [7:0] ref_inv [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic build_model();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] xi, bx, s;
      bx = 8'(x);
      xi = 8'h00;
      for (int y = 1; y < 256; y++)
        if (bx != 8'h00 && gmul(bx, 8'(y)) == 8'h01) xi = 8'(y);
      s = xi ^ rotl(xi, 1) ^ rotl(xi, 2) ^ rotl(xi, 3) ^ rotl(xi, 4) ^ 8'h63;
      ref_fwd[x] = s;
      ref_inv[s] = bx;
    end
  endtask

  function automatic logic [127:0] model(input logic inv, input logic [127:0] d, input int lanes);
    logic [127:0] r = '0;
    for (int i = 0; i < lanes; i++)
      r[8*i +: 8] = inv ? ref_inv[d[8*i +: 8]] : ref_fwd[d[8*i +: 8]];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        inv;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  bit   mon_en     = 1'b0;
  bit   rand_ready = 1'b0;

  // Words in flight at a falling edge are exactly those pushed but not yet popped.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      exp_t e;
      logic [127:0] m;
      check("busy_vs_inflight", 128'(a_busy), 128'(q.size() != 0));
      if (a_out_ready) check("in_ready_at_full_rate", 128'(a_in_ready), 128'(1));
      if (a_out_valid && a_out_ready) begin
        if (q.size() == 0) begin
          check("spurious_output", 128'(a_out_valid), 128'(0));
        end else begin
          e = q.pop_front();
          check("sb_out_data", 128'(a_out_data), 128'(e.data));
          check("sb_out_inv", 128'(a_out_inv), 128'(e.inv));
        end
      end
      if (a_in_valid && a_in_ready) begin
        m = model(a_in_inv, 128'(a_in_data), 4);
        e.inv  = a_in_inv;
        e.data = m[31:0];
        q.push_back(e);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      a_out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_a(input logic inv, input logic [31:0] d);
    int n = 0;
    bit acc;
    a_in_valid = 1'b1;
    a_in_inv   = inv;
    a_in_data  = d;
    do begin
      @(negedge clk);
      acc = a_in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) check("send_timeout", 128'(a_in_ready), 128'(1));
    a_in_valid = 1'b0;
  endtask

  task automatic drain_a();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 128'(q.size()), 128'(0));
  endtask

  task automatic latency_a(input logic inv, input logic [31:0] d, input logic [31:0] exp);
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_inv    = inv;
    a_in_data   = d;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    check("lat_not_yet_1", 128'(a_out_valid), 128'(0));
    @(posedge clk); #1;
    check("lat_not_yet_2", 128'(a_out_valid), 128'(0));
    @(posedge clk); #1;
    check("lat_out_valid", 128'(a_out_valid), 128'(1));
    check("lat_out_data", 128'(a_out_data), 128'(exp));
    check("lat_out_inv", 128'(a_out_inv), 128'(inv));
    @(posedge clk); #1;
    check("lat_consumed", 128'(a_out_valid), 128'(0));
  endtask

  typedef struct {
    logic         inv;
    logic [127:0] data;
    logic [127:0] exp;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    int   accepted;
    logic [127:0] m;

    tbl[0] = '{1'b0, {4{32'h01ff5300}}, {4{32'h7c16ed63}}};
    tbl[1] = '{1'b1, {4{32'h7c16ed63}}, {4{32'h01ff5300}}};
    tbl[2] = '{1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230};
    tbl[3] = '{1'b1, 128'hd42711aee0bf98f1b8b45de51e415230, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
    tbl[4] = '{1'b0, 128'h0, {16{8'h63}}};
    tbl[5] = '{1'b1, {16{8'h63}}, 128'h0};

    build_model();

    rst = 1'b1;
    a_in_valid = 1'b1; a_in_inv = 1'b1; a_in_data = 32'hdeadbeef; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_inv = 1'b0; b_in_data = '0;           b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    a_in_valid = 1'b0;

    @(negedge clk);
    check("rst_a_out_valid", 128'(a_out_valid), 128'(0));
    check("rst_a_out_data", 128'(a_out_data), 128'(0));
    check("rst_a_out_inv", 128'(a_out_inv), 128'(0));
    check("rst_a_busy", 128'(a_busy), 128'(0));
    check("rst_a_in_ready", 128'(a_in_ready), 128'(1));
    check("rst_b_out_valid", 128'(b_out_valid), 128'(0));
    check("rst_b_out_data", b_out_data, 128'(0));
    check("rst_b_busy", 128'(b_busy), 128'(0));
    check("rst_b_in_ready", 128'(b_in_ready), 128'(1));
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("reset_cycle_input_dropped", 128'(a_out_valid), 128'(0));
    end

    latency_a(1'b0, 32'h01ff5300, 32'h7c16ed63);
    latency_a(1'b1, 32'h7c16ed63, 32'h01ff5300);

    // Table vectors on the 16-lane single-stage instance, modes alternating at full rate.
    @(posedge clk); #1;
    b_in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b_in_inv  = tbl[i].inv;
      b_in_data = tbl[i].data;
      @(negedge clk);
      check("tbl_in_ready", 128'(b_in_ready), 128'(1));
      @(posedge clk); #1;
      check("tbl_out_valid", 128'(b_out_valid), 128'(1));
      check("tbl_out_data", b_out_data, tbl[i].exp);
      check("tbl_out_inv", 128'(b_out_inv), 128'(tbl[i].inv));
    end
    b_in_valid = 1'b0;
    @(posedge clk); #1;
    check("tbl_idle_valid", 128'(b_out_valid), 128'(0));
    check("tbl_idle_busy", 128'(b_busy), 128'(0));

    // All 256 byte values in both modes, back to back.
    mon_en = 1'b1;
    a_out_ready = 1'b1;
    for (int inv = 0; inv < 2; inv++)
      for (int w = 0; w < 64; w++)
        send_a(inv[0], {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
    drain_a();

    // Backpressure: only PIPE words fit, head word held on the output.
    a_out_ready = 1'b0;
    accepted = 0;
    for (int c = 0; c < 8; c++) begin
      a_in_valid = (accepted < 5);
      a_in_inv   = accepted[0];
      a_in_data  = 32'h01010101 * (accepted + 1);
      @(negedge clk);
      if (a_in_valid && a_in_ready) accepted++;
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    check("bp_accepted", 128'(accepted), 128'(3));
    @(negedge clk);
    m = model(1'b0, 128'(32'h01010101), 4);
    check("bp_in_ready_low", 128'(a_in_ready), 128'(0));
    check("bp_out_valid", 128'(a_out_valid), 128'(1));
    check("bp_head_held", 128'(a_out_data), m);
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    for (int w = accepted; w < 5; w++)
      send_a(w[0], 32'h01010101 * (w + 1));
    drain_a();

    // Random stalls on both sides against the scoreboard.
    rand_ready = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send_a(1'($urandom_range(0, 1)), $urandom);
    end
    rand_ready = 1'b0;
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    drain_a();

    // Reset with two words in flight: both must vanish.
    mon_en = 1'b0;
    q.delete();
    a_out_ready = 1'b0;
    send_a(1'b1, 32'h7c16ed63);
    send_a(1'b1, 32'h01ff5300);
    check("pre_rst_busy", 128'(a_busy), 128'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_out_valid", 128'(a_out_valid), 128'(0));
    check("mid_rst_busy", 128'(a_busy), 128'(0));
    check("mid_rst_in_ready", 128'(a_in_ready), 128'(1));
    check("mid_rst_out_data", 128'(a_out_data), 128'(0));
    check("mid_rst_out_inv", 128'(a_out_inv), 128'(0));
    a_out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("flushed_never_emitted", 128'(a_out_valid), 128'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_subbytes_pipe.md
# aes_subbytes_pipe

Parametrised, pipelined AES byte-substitution engine: applies the forward S-box (encryption) or inverse S-box (decryption) to LANES bytes per transaction, selectable per transaction. It succeeds the single-byte combinational S-box lookup and sits between the AddRoundKey and ShiftRows/InvShiftRows stages of the round datapath. It also serves the key-expansion SubWord step when LANES=4. Valid/ready handshakes on both sides give full throughput under backpressure.

## Interface
- LANES, 16: bytes substituted per transaction, 1..16.
- PIPE, 1: register stages between acceptance and output, 1..4.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  engine accepts input this cycle.
- in_inv  in  1  0 = forward S-box, 1 = inverse S-box; sampled with in_data.
- in_data  in  8*LANES  lane i = bits [8i+7:8i].
- out_valid  out  1  output word present.
- out_ready  in  1  consumer accepts output this cycle.
- out_inv  out  1  mode that produced out_data.
- out_data  out  8*LANES  substituted bytes, same lane mapping.
- busy  out  1  any pipeline stage holds a valid word.

## Operation
- Transfer occurs on a cycle where valid && ready are both high, on each side independently.
- Lookup is combinational on in_data/in_inv ahead of stage 1. Each lane is independent: out byte i = in_inv ? InvSbox(byte i) : Sbox(byte i), per FIPS-197.
- Stages 1..PIPE each hold {valid, inv, data}. Stage PIPE drives out_valid/out_inv/out_data directly from registers.
- Stage k loads from stage k-1 (stage 0 = accepted input) when stage k is empty or stage k is advancing. Otherwise it holds its value unchanged.
- in_ready = !v1 || adv1; advk = vk && (k==PIPE ? out_ready : (!v(k+1) || adv(k+1))). The ready path is combinational from out_ready; no bubbles are inserted.
- out_data and out_inv are stable while out_valid && !out_ready.
- Mode may change on every transaction. No draining is needed between modes.
- busy = OR of stage valids.
- Reset: all stage valids clear to 0, data/inv registers clear to 0. After reset, out_valid=0, out_data=0, out_inv=0, busy=0, and in_ready=1 (combinational from cleared valids). Reset mid-stream discards every in-flight word. An in_valid present in the reset cycle is not accepted.

## Timing
- Latency: a word accepted at edge n appears with out_valid=1 after edge n+PIPE-1, so PIPE cycles from acceptance to output availability.
- Throughput: 1 word/cycle while out_ready=1.
- Capacity: PIPE words in flight. With out_ready held low, exactly PIPE words are accepted, then in_ready falls.
- Simultaneous accept and emit when full: permitted. When the last stage advances, the chain shifts and in_ready=1 in the same cycle.
- No combinational path from in_data to out_data.

## Structure
- Shared package aes_pkg holds the 256-entry forward and inverse S-box constant tables and the functions sbox_fwd(byte) / sbox_inv(byte). The round and key-expansion blocks use the same tables.
- Sub-module aes_sbox_dual: one combinational byte lane with inputs (byte, inv) and output byte. It is instantiated LANES times via generate.
- The top level contains only the generate loop and the PIPE-stage valid/data register chain.

## Test plan
- Forward single word, LANES=4, PIPE=1: in_data=0x01ff5300, inv=0, out_ready=1 -> one cycle later out_valid=1, out_data=0x7c16ed63, out_inv=0.
- Inverse round-trip: feed 0x7c16ed63 with inv=1 -> out_data=0x01ff5300. Exhaustively cover all 256 byte values in both modes, checking InvSbox(Sbox(x))=x, and check FIPS-197 anchor points Sbox(0x00)=0x63, Sbox(0xff)=0x16, InvSbox(0x63)=0x00.
- Backpressure, PIPE=3: out_ready=0, stream words 1..5 -> exactly 3 accepted, then in_ready=0 and out_data holds word 1. Release out_ready -> words 1..5 emerge in order with no duplication or loss.
- Mode interleave, LANES=16: back-to-back words with inv alternating 0,1,0 at full rate -> each output matches its own mode, out_inv tracks in_inv, throughput 1/cycle.
- Random stall: randomized in_valid/out_ready over 10k words, compared against a scoreboard -> identical in-order output and 100% throughput whenever out_ready=1 and input is available.
- Reset mid-operation: PIPE=2 with two words in flight, rst=1 for one cycle -> next cycle out_valid=0, busy=0, in_ready=1, out_data=0. Neither word is ever emitted.
